wb_writer: RTL and testbench

//  Writeback-stage producer for the GPR file's single write port. Merges MEM-stage results
//  (ALU values, sub-word loads) and late multi-cycle mul/div results into registered
//  rf_wen/rf_windex/rf_wdata/rf_exception; rf_exception drives the regfile's exception_in.

---
 rtl/wb_writer_pkg.sv | 27 ++
 rtl/wb_load_align.sv | 27 ++
 rtl/wb_writer.sv | 166 ++++++++++++++++
 tb/tb_wb_writer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_writer_pkg.sv
// Shared writeback definitions: the `TRAP_STALL reset exception code, exception width,
// load-size encodings (common with the MEM stage) and the writeback source selector.
`ifndef TRAP_STALL
`define TRAP_STALL 8'hFF
`endif

package wb_writer_pkg;

  localparam int EXC_W = 8;
  localparam logic [EXC_W-1:0] TRAP_STALL_CODE = `TRAP_STALL;

  typedef enum logic [1:0] {
    LD_NONE = 2'b00,
    LD_BYTE = 2'b01,
    LD_HALF = 2'b10,
    LD_WORD = 2'b11
  } ld_size_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TRAP,
    SEL_BUF,
    SEL_MEM,
    SEL_MD
  } wb_sel_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational extraction and zero/sign extension of sub-word loads from the aligned load word.
module wb_load_align
  import wb_writer_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*addr_lo_i +: 8];
    // addr_lo[0] is ignored for halves; misalignment is trapped before this stage.
    half_sel = word_i[16*addr_lo_i[1] +: 16];
    data_o   = word_i;
    case (size_i)
      LD_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      LD_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_writer.sv
// Writeback-port arbiter: merges MEM results with a one-entry mul/div buffer and a starvation stall.
// Optional WB_BYPASS_EN adds fwd_valid/fwd_index/fwd_data showing the write selected this cycle.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [EXC_W-1:0] mem_exception,
  input  logic             mem_wen,
  input  logic [4:0]       mem_windex,
  input  logic [31:0]      mem_wdata,
  input  logic [1:0]       mem_ld_size,
  input  logic             mem_ld_signed,
  input  logic [1:0]       mem_addr_lo,
  input  logic             md_valid,
  output logic             md_ready,
  input  logic [4:0]       md_windex,
  input  logic [31:0]      md_wdata,
  output logic             rf_wen,
  output logic [4:0]       rf_windex,
  output logic [31:0]      rf_wdata,
  output logic [EXC_W-1:0] rf_exception,
  output logic             stall_req
`ifdef WB_BYPASS_EN
  ,
  output logic             fwd_valid,
  output logic [4:0]       fwd_index,
  output logic [31:0]      fwd_data
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic             rf_wen_q, rf_wen_d;
  logic [4:0]       rf_windex_q, rf_windex_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic [EXC_W-1:0] rf_exception_q, rf_exception_d;
  logic             stall_q, stall_d;
  logic             buf_full_q, buf_full_d;
  logic [4:0]       buf_index_q, buf_index_d;
  logic [31:0]      buf_data_q, buf_data_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic [31:0]      load_data;
  logic [CNT_W-1:0] starve_inc;
  logic             md_accept;
  logic             wr_valid;
  wb_sel_e          sel;

  wb_load_align u_load_align (
    .word_i    (mem_wdata),
    .size_i    (mem_ld_size),
    .signed_i  (mem_ld_signed),
    .addr_lo_i (mem_addr_lo),
    .data_o    (load_data)
  );

  assign md_ready   = !rst && !buf_full_q;
  assign md_accept  = md_valid && md_ready;
  assign starve_inc = starve_q + 1'b1;

  always_comb begin
    sel = SEL_NONE;
    if (mem_valid && mem_exception != '0) begin
      sel = SEL_TRAP;
    end else if (stall_q) begin
      sel = SEL_BUF;
    end else if (mem_valid && mem_wen) begin
      sel = SEL_MEM;
    end else if (buf_full_q) begin
      sel = SEL_BUF;
    end else if (md_accept) begin
      sel = SEL_MD;
    end
  end

  always_comb begin
    wr_valid       = 1'b0;
    rf_windex_d    = rf_windex_q;
    rf_wdata_d     = rf_wdata_q;
    rf_exception_d = '0;
    buf_full_d     = buf_full_q;
    buf_index_d    = buf_index_q;
    buf_data_d     = buf_data_q;
    starve_d       = starve_q;
    stall_d        = 1'b0;
    case (sel)
      SEL_TRAP: begin
        rf_exception_d = mem_exception;
        buf_full_d     = 1'b0;
        starve_d       = '0;
      end
      SEL_BUF: begin
        wr_valid    = 1'b1;
        rf_windex_d = buf_index_q;
        rf_wdata_d  = buf_data_q;
        buf_full_d  = 1'b0;
        starve_d    = '0;
      end
      SEL_MEM: begin
        wr_valid    = 1'b1;
        rf_windex_d = mem_windex;
        rf_wdata_d  = load_data;
        // A younger MEM write to the buffered destination makes the buffered result stale.
        if (buf_full_q && buf_index_q == mem_windex) begin
          buf_full_d = 1'b0;
          starve_d   = '0;
        end else if (buf_full_q) begin
          starve_d = starve_inc;
          stall_d  = (starve_inc >= CNT_W'(STARVE_MAX));
        end else if (md_accept) begin
          buf_full_d  = 1'b1;
          buf_index_d = md_windex;
          buf_data_d  = md_wdata;
        end
      end
      SEL_MD: begin
        wr_valid    = 1'b1;
        rf_windex_d = md_windex;
        rf_wdata_d  = md_wdata;
      end
      default: ;
    endcase
    rf_wen_d = wr_valid && (rf_windex_d != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q       <= 1'b0;
      rf_windex_q    <= '0;
      rf_wdata_q     <= '0;
      rf_exception_q <= TRAP_STALL_CODE;
      stall_q        <= 1'b0;
      buf_full_q     <= 1'b0;
      buf_index_q    <= '0;
      buf_data_q     <= '0;
      starve_q       <= '0;
    end else begin
      rf_wen_q       <= rf_wen_d;
      rf_windex_q    <= rf_windex_d;
      rf_wdata_q     <= rf_wdata_d;
      rf_exception_q <= rf_exception_d;
      stall_q        <= stall_d;
      buf_full_q     <= buf_full_d;
      buf_index_q    <= buf_index_d;
      buf_data_q     <= buf_data_d;
      starve_q       <= starve_d;
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_windex    = rf_windex_q;
  assign rf_wdata     = rf_wdata_q;
  assign rf_exception = rf_exception_q;
  assign stall_req    = stall_q;

`ifdef WB_BYPASS_EN
  assign fwd_valid = !rst && rf_wen_d;
  assign fwd_index = rf_windex_d;
  assign fwd_data  = rf_wdata_d;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Self-checking bench for wb_writer: directed scenarios plus randomized traffic against a queue model.
module tb_wb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [7:0]  mem_exception = 8'h00;
  logic        mem_wen = 1'b0;
  logic [4:0]  mem_windex = 5'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [1:0]  mem_ld_size = 2'd0;
  logic        mem_ld_signed = 1'b0;
  logic [1:0]  mem_addr_lo = 2'd0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_windex = 5'd0;
  logic [31:0] md_wdata = 32'd0;
  logic        rf_wen;
  logic [4:0]  rf_windex;
  logic [31:0] rf_wdata;
  logic [7:0]  rf_exception;
  logic        stall_req;
`ifdef WB_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_index;
  logic [31:0] fwd_data;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] trap_code;

  wb_writer #(.STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_exception(mem_exception), .mem_wen(mem_wen),
    .mem_windex(mem_windex), .mem_wdata(mem_wdata), .mem_ld_size(mem_ld_size),
    .mem_ld_signed(mem_ld_signed), .mem_addr_lo(mem_addr_lo),
    .md_valid(md_valid), .md_ready(md_ready), .md_windex(md_windex), .md_wdata(md_wdata),
    .rf_wen(rf_wen), .rf_windex(rf_windex), .rf_wdata(rf_wdata),
    .rf_exception(rf_exception), .stall_req(stall_req)
`ifdef WB_BYPASS_EN
    , .fwd_valid(fwd_valid), .fwd_index(fwd_index), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: pending mul/div results as a queue, expectations from the writeback rules.
  typedef struct packed {logic [4:0] idx; logic [31:0] data;} md_t;
  md_t         pend[$];
  int          starve;
  bit          m_stall, m_wr, m_wen;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  logic [7:0]  m_exc;

  function automatic logic [31:0] ld_ref(logic [31:0] w, logic [1:0] sz, logic sg, logic [1:0] lo);
    logic [31:0] v;
    if (sz == 2'd1) begin
      v = (w >> (8 * lo)) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd2) begin
      v = (w >> (16 * (lo / 2))) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic model_step();
    bit         rdy, wr, nstall;
    logic [4:0] wi;
    logic [31:0] wd;
    md_t        e;
    rdy = !rst && pend.size() == 0;
    wr = 0; nstall = 0; wi = 0; wd = 0;
    if (rst) begin
      pend.delete(); starve = 0;
      m_wr = 0; m_wen = 0; m_exc = trap_code; m_stall = 0;
      return;
    end
    m_exc = 8'h00;
    if (mem_valid && mem_exception != 0) begin
      m_exc = mem_exception;
      pend.delete(); starve = 0;
    end else if (m_stall) begin
      e = pend.pop_front(); wr = 1; wi = e.idx; wd = e.data; starve = 0;
    end else if (mem_valid && mem_wen) begin
      wr = 1; wi = mem_windex;
      wd = ld_ref(mem_wdata, mem_ld_size, mem_ld_signed, mem_addr_lo);
      if (pend.size() != 0 && pend[0].idx == mem_windex) begin
        pend.delete(); starve = 0;
      end else if (pend.size() != 0) begin
        starve = starve + 1;
        if (starve >= 2) nstall = 1;
      end else if (md_valid && rdy) begin
        pend.push_back({md_windex, md_wdata});
      end
    end else if (pend.size() != 0) begin
      e = pend.pop_front(); wr = 1; wi = e.idx; wd = e.data; starve = 0;
    end else if (md_valid && rdy) begin
      wr = 1; wi = md_windex; wd = md_wdata;
    end
    m_wr = wr; m_wen = wr && (wi != 0); m_idx = wi; m_data = wd; m_stall = nstall;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 0; mem_exception = 0; mem_wen = 0; mem_windex = 0; mem_wdata = 0;
    mem_ld_size = 0; mem_ld_signed = 0; mem_addr_lo = 0;
    md_valid = 0; md_windex = 0; md_wdata = 0;
  endtask

  task automatic mem_write(logic [4:0] idx, logic [31:0] data);
    mem_valid = 1; mem_exception = 0; mem_wen = 1; mem_windex = idx; mem_wdata = data;
    mem_ld_size = 2'd0; mem_ld_signed = 0; mem_addr_lo = 0;
  endtask

  task automatic md_offer(logic [4:0] idx, logic [31:0] data);
    md_valid = 1; md_windex = idx; md_wdata = data;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    tick(); tick();
    n_checks++; if (rf_exception !== trap_code) begin n_fail++; $display("FAIL reset_exc act=%h exp=%h", rf_exception, trap_code); end
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen act=%b exp=0", rf_wen); end
    n_checks++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL reset_md_ready act=%b exp=0", md_ready); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall act=%b exp=0", stall_req); end
    n_checks++; if (rf_wdata !== 32'd0 || rf_windex !== 5'd0) begin n_fail++; $display("FAIL reset_idx_data act=%h/%h exp=0/0", rf_windex, rf_wdata); end
    rst = 0;
    tick();
    n_checks++; if (rf_exception !== 8'h00) begin n_fail++; $display("FAIL release_exc act=%h exp=00", rf_exception); end
    n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL release_md_ready act=%b exp=1", md_ready); end
    $display("test_reset done");
  endtask

  task automatic test_loads();
    logic [1:0]  sz_tab [9]  = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0};
    logic        sg_tab [9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  lo_tab [9]  = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd1, 2'd0};
    logic [31:0] exp_tab [9] = '{32'hFFFFFFF1, 32'h000080F1, 32'h00000022, 32'h00007F22,
                                 32'hFFFF80F1, 32'h0000007F, 32'hFFFFFF80, 32'h80F17F22, 32'h80F17F22};
    for (int i = 0; i < 9; i++) begin
      mem_write(5'd3, 32'h80F17F22);
      mem_ld_size = sz_tab[i]; mem_ld_signed = sg_tab[i]; mem_addr_lo = lo_tab[i];
      tick();
      n_checks++; if (rf_wdata !== exp_tab[i] || rf_wen !== 1'b1) begin n_fail++; $display("FAIL load_%0d act=%h wen=%b exp=%h wen=1", i, rf_wdata, rf_wen, exp_tab[i]); end
      $display("load %0d size=%0d signed=%0d lo=%0d data=%h", i, sz_tab[i], sg_tab[i], lo_tab[i], rf_wdata);
    end
    idle(); tick();
  endtask

  task automatic test_conflict();
    mem_write(5'd5, 32'd1); md_offer(5'd7, 32'd9);
    #1;
    n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL conflict_ready0 act=%b exp=1", md_ready); end
    tick();
    n_checks++; if (rf_wen !== 1'b1 || rf_windex !== 5'd5 || rf_wdata !== 32'd1) begin n_fail++; $display("FAIL conflict_mem act=%b/%0d/%h exp=1/5/1", rf_wen, rf_windex, rf_wdata); end
    n_checks++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL conflict_ready1 act=%b exp=0", md_ready); end
    idle(); tick();
    n_checks++; if (rf_wen !== 1'b1 || rf_windex !== 5'd7 || rf_wdata !== 32'd9) begin n_fail++; $display("FAIL conflict_md act=%b/%0d/%h exp=1/7/9", rf_wen, rf_windex, rf_wdata); end
    n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL conflict_ready2 act=%b exp=1", md_ready); end
    tick();
    $display("test_conflict done");
  endtask

  task automatic test_starve();
    mem_write(5'd1, 32'h11); md_offer(5'd7, 32'h77);
    tick();
    md_valid = 0;
    mem_write(5'd2, 32'h22); tick();
    n_checks++; if (rf_windex !== 5'd2 || stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_w1 act=%0d stall=%b exp=2 stall=0", rf_windex, stall_req); end
    mem_write(5'd3, 32'h33); tick();
    n_checks++; if (rf_windex !== 5'd3 || stall_req !== 1'b1) begin n_fail++; $display("FAIL starve_w2 act=%0d stall=%b exp=3 stall=1", rf_windex, stall_req); end
    mem_write(5'd4, 32'h44); tick();
    n_checks++; if (rf_wen !== 1'b1 || rf_windex !== 5'd7 || rf_wdata !== 32'h77 || stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_drain act=%b/%0d/%h stall=%b exp=1/7/77 stall=0", rf_wen, rf_windex, rf_wdata, stall_req); end
    n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL starve_ready act=%b exp=1", md_ready); end
    tick();
    n_checks++; if (rf_windex !== 5'd4 || rf_wdata !== 32'h44 || stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_w3 act=%0d/%h stall=%b exp=4/44 stall=0", rf_windex, rf_wdata, stall_req); end
    idle(); tick();
    $display("test_starve done");
  endtask

  task automatic test_hazard();
    mem_write(5'd1, 32'h1); md_offer(5'd9, 32'hAA);
    tick();
    md_valid = 0;
    mem_write(5'd9, 32'hBB); tick();
    n_checks++; if (rf_wen !== 1'b1 || rf_windex !== 5'd9 || rf_wdata !== 32'hBB) begin n_fail++; $display("FAIL hazard_mem act=%b/%0d/%h exp=1/9/bb", rf_wen, rf_windex, rf_wdata); end
    n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL hazard_ready act=%b exp=1", md_ready); end
    idle(); tick();
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL hazard_nodrain act=%b exp=0", rf_wen); end
    $display("test_hazard done");
  endtask

  task automatic test_trap();
    mem_write(5'd1, 32'h1); md_offer(5'd2, 32'h55);
    tick();
    md_valid = 0;
    mem_write(5'd6, 32'h66); mem_exception = 8'h04; tick();
    n_checks++; if (rf_exception !== 8'h04 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL trap_out act=%h wen=%b exp=04 wen=0", rf_exception, rf_wen); end
    n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL trap_flush act=%b exp=1", md_ready); end
    idle(); tick();
    n_checks++; if (rf_wen !== 1'b0 || rf_exception !== 8'h00) begin n_fail++; $display("FAIL trap_after act=%b/%h exp=0/00", rf_wen, rf_exception); end
    $display("test_trap done");
  endtask

  task automatic test_r0();
    md_offer(5'd0, 32'h1234); tick();
    n_checks++; if (rf_wen !== 1'b0 || rf_wdata !== 32'h1234 || rf_windex !== 5'd0) begin n_fail++; $display("FAIL r0_write act=%b/%0d/%h exp=0/0/1234", rf_wen, rf_windex, rf_wdata); end
    idle(); tick();
    $display("test_r0 done");
  endtask

  task automatic test_reset_mid();
    mem_write(5'd1, 32'h1); md_offer(5'd3, 32'h33);
    tick();
    idle(); rst = 1; tick();
    n_checks++; if (rf_wen !== 1'b0 || rf_exception !== trap_code) begin n_fail++; $display("FAIL rstmid_out act=%b/%h exp=0/%h", rf_wen, rf_exception, trap_code); end
    rst = 0; tick();
    n_checks++; if (rf_wen !== 1'b0 || rf_exception !== 8'h00) begin n_fail++; $display("FAIL rstmid_discard act=%b/%h exp=0/00", rf_wen, rf_exception); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    bit exp_ready;
    int fail0;
    fail0 = n_fail;
    for (int c = 0; c < 800; c++) begin
      rst           = (c < 2) || ($urandom_range(0, 63) == 0);
      mem_valid     = ($urandom_range(0, 3) != 0);
      mem_exception = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      mem_wen       = ($urandom_range(0, 3) != 0);
      mem_windex    = 5'($urandom_range(0, 7));
      mem_wdata     = $urandom;
      mem_ld_size   = 2'($urandom_range(0, 3));
      mem_ld_signed = 1'($urandom_range(0, 1));
      mem_addr_lo   = 2'($urandom_range(0, 3));
      md_valid      = 1'($urandom_range(0, 1));
      md_windex     = 5'($urandom_range(0, 7));
      md_wdata      = $urandom;
      #1;
      exp_ready = !rst && pend.size() == 0;
      n_checks++; if (md_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc=%0d act=%b exp=%b", c, md_ready, exp_ready); end
      model_step();
`ifdef WB_BYPASS_EN
      n_checks++; if (fwd_valid !== m_wen || (m_wr && (fwd_index !== m_idx || fwd_data !== m_data))) begin n_fail++; $display("FAIL rnd_fwd cyc=%0d act=%b/%0d/%h exp=%b/%0d/%h", c, fwd_valid, fwd_index, fwd_data, m_wen, m_idx, m_data); end
`endif
      tick();
      n_checks++; if (rf_wen !== m_wen || rf_exception !== m_exc || stall_req !== m_stall) begin n_fail++; $display("FAIL rnd_ctl cyc=%0d act=%b/%h/%b exp=%b/%h/%b", c, rf_wen, rf_exception, stall_req, m_wen, m_exc, m_stall); end
      if (m_wr) begin
        n_checks++; if (rf_windex !== m_idx || rf_wdata !== m_data) begin n_fail++; $display("FAIL rnd_data cyc=%0d act=%0d/%h exp=%0d/%h", c, rf_windex, rf_wdata, m_idx, m_data); end
      end
    end
    rst = 0; idle(); tick();
    $display("test_random done errors=%0d", n_fail - fail0);
  endtask

  initial begin
    trap_code = wb_writer_pkg::TRAP_STALL_CODE;
    test_reset();
    test_loads();
    test_conflict();
    test_starve();
    test_hazard();
    test_trap();
    test_r0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
